// File: rtl/vga_pkg.sv
// Shared timing defaults, FSM encoding and RGB888 field layout for the VGA output path.
package vga_pkg;

    localparam int unsigned DEF_H_ACTIVE   = 640;
    localparam int unsigned DEF_H_FP       = 16;
    localparam int unsigned DEF_H_SYNC     = 96;
    localparam int unsigned DEF_H_BP       = 48;
    localparam int unsigned DEF_V_ACTIVE   = 480;
    localparam int unsigned DEF_V_FP       = 10;
    localparam int unsigned DEF_V_SYNC     = 2;
    localparam int unsigned DEF_V_BP       = 33;
    localparam int unsigned DEF_FIFO_DEPTH = 16;

    localparam int unsigned DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int unsigned DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int unsigned DEF_HS_START = DEF_H_ACTIVE + DEF_H_FP;
    localparam int unsigned DEF_HS_END   = DEF_HS_START + DEF_H_SYNC;
    localparam int unsigned DEF_VS_START = DEF_V_ACTIVE + DEF_V_FP;
    localparam int unsigned DEF_VS_END   = DEF_VS_START + DEF_V_SYNC;

    localparam int unsigned CNT_W = 10;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } vga_state_t;

    localparam int unsigned RGB_CH_W  = 8;
    localparam int unsigned RGB_R_LSB = 16;
    localparam int unsigned RGB_G_LSB = 8;
    localparam int unsigned RGB_B_LSB = 0;

endpackage

// File: rtl/vga_pixel_fifo.sv
// First-word-fall-through pixel FIFO with level, full/empty and synchronous flush.
module vga_pixel_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 24
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    // Extra pointer bit distinguishes full from empty; level never exceeds DEPTH.
    always_comb begin
        level   = wr_ptr - rd_ptr;
        full    = level[AW];
        empty   = (wr_ptr == rd_ptr);
        rd_data = mem[rd_ptr[AW-1:0]];
        do_wr   = wr_en && !full && !flush;
        do_rd   = rd_en && !empty;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/vga_stream_out.sv
// VGA timing generator and registered RGB/sync/DE output fed from a pixel FIFO.
// Optional macro VGA_UNDERFLOW_RESYNC_EN: after an underflow, flush and restart at frame end.
module vga_stream_out
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
    parameter int unsigned H_FP       = DEF_H_FP,
    parameter int unsigned H_SYNC     = DEF_H_SYNC,
    parameter int unsigned H_BP       = DEF_H_BP,
    parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
    parameter int unsigned V_FP       = DEF_V_FP,
    parameter int unsigned V_SYNC     = DEF_V_SYNC,
    parameter int unsigned V_BP       = DEF_V_BP,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pixel_valid,
    output logic        pixel_ready,
    input  logic [23:0] pixel_data,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_de,
    output logic        underflow
);

    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    localparam int unsigned      LVL_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LVL_W-1:0] START_LVL = LVL_W'(FIFO_DEPTH / 2);

    vga_state_t       state;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             active;
    logic             hs_zone;
    logic             vs_zone;
    logic             rd_en;
    logic             flush;
    logic [23:0]      fifo_head;
    logic [23:0]      pixel_out;
    logic             fifo_full;
    logic             fifo_empty;
    logic [LVL_W-1:0] fifo_level;

    always_comb begin
        active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        hs_zone   = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
        vs_zone   = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
        rd_en     = (state == RUN) && active;
        pixel_out = (active && !fifo_empty) ? fifo_head : '0;
`ifdef VGA_UNDERFLOW_RESYNC_EN
        flush     = (state == RUN) && underflow && (h_cnt == H_LAST) && (v_cnt == V_LAST);
`else
        flush     = 1'b0;
`endif
    end

    assign pixel_ready = !fifo_full;

    vga_pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (24)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .wr_en   (pixel_valid),
        .wr_data (pixel_data),
        .rd_en   (rd_en),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            h_cnt     <= '0;
            v_cnt     <= '0;
            vga_r     <= '0;
            vga_g     <= '0;
            vga_b     <= '0;
            vga_hs    <= 1'b1;
            vga_vs    <= 1'b1;
            vga_de    <= 1'b0;
            underflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    h_cnt  <= '0;
                    v_cnt  <= '0;
                    vga_r  <= '0;
                    vga_g  <= '0;
                    vga_b  <= '0;
                    vga_hs <= 1'b1;
                    vga_vs <= 1'b1;
                    vga_de <= 1'b0;
                    if (fifo_level >= START_LVL) state <= RUN;
                end
                RUN: begin
                    // Outputs lag the counters by one clock; sync, DE and RGB share the stage.
                    vga_de <= active;
                    vga_hs <= ~hs_zone;
                    vga_vs <= ~vs_zone;
                    vga_r  <= pixel_out[RGB_R_LSB +: RGB_CH_W];
                    vga_g  <= pixel_out[RGB_G_LSB +: RGB_CH_W];
                    vga_b  <= pixel_out[RGB_B_LSB +: RGB_CH_W];
                    if (active && fifo_empty) underflow <= 1'b1;
                    if (flush) begin
                        state <= IDLE;
                        h_cnt <= '0;
                        v_cnt <= '0;
                    end else if (h_cnt == H_LAST) begin
                        h_cnt <= '0;
                        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
                    end else begin
                        h_cnt <= h_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_stream_out.sv
// Randomized bench for vga_stream_out against a frame-position reference model, on reduced timing.
module tb_vga_stream_out;

    localparam int unsigned HA    = 16;
    localparam int unsigned HFP   = 4;
    localparam int unsigned HSY   = 6;
    localparam int unsigned HBP   = 5;
    localparam int unsigned VA    = 8;
    localparam int unsigned VFP   = 2;
    localparam int unsigned VSY   = 2;
    localparam int unsigned VBP   = 3;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned HT    = HA + HFP + HSY + HBP;
    localparam int unsigned VT    = VA + VFP + VSY + VBP;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        pixel_valid = 1'b0;
    logic        pixel_ready;
    logic [23:0] pixel_data = '0;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs, vga_de, underflow;

    vga_stream_out #(
        .H_ACTIVE   (HA),
        .H_FP       (HFP),
        .H_SYNC     (HSY),
        .H_BP       (HBP),
        .V_ACTIVE   (VA),
        .V_FP       (VFP),
        .V_SYNC     (VSY),
        .V_BP       (VBP),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pixel_valid (pixel_valid),
        .pixel_ready (pixel_ready),
        .pixel_data  (pixel_data),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .vga_de      (vga_de),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: pixel queue plus position inside the running frame.
    logic [23:0] q[$];
    bit          run;
    int unsigned t;
    bit          uf;
    logic [23:0] e_rgb;
    bit          e_hs, e_vs, e_de;

    bit          src_on;
    int unsigned src_prob, src_limit, src_idx;
    logic [23:0] cur_data;

    bit          mon_en;
    int unsigned cyc, de_rise, frame_de, hs_fall, vs_fall;
    logic        p_de, p_hs, p_vs;

    function automatic logic [23:0] gen_pixel(input int unsigned idx);
        logic [23:0] r;
        r = 24'($urandom) | 24'h000100;
        return (idx % HA == 0) ? 24'h0000FF : r;
    endfunction

    function automatic logic [31:0] obs_vec();
        return {3'b0, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_de, underflow, pixel_ready};
    endfunction

    function automatic logic [31:0] exp_vec();
        return {3'b0, e_rgb, e_hs, e_vs, e_de, uf, (q.size() < DEPTH)};
    endfunction

    task automatic model_clear();
        q.delete();
        run = 1'b0; t = 0; uf = 1'b0;
        e_rgb = '0; e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0;
        src_idx = 0;
        cur_data = gen_pixel(0);
    endtask

    task automatic model_edge();
        bit push, fl, act;
        int unsigned h, v;
        push = pixel_valid && (q.size() < DEPTH);
        fl = 1'b0;
        if (!run) begin
            e_rgb = '0; e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0;
            if (q.size() >= DEPTH / 2) begin
                run = 1'b1;
                t = 0;
            end
        end else begin
            h = t % HT;
            v = (t / HT) % VT;
            act  = (h < HA) && (v < VA);
            e_de = act;
            e_hs = !(h >= HA + HFP && h < HA + HFP + HSY);
            e_vs = !(v >= VA + VFP && v < VA + VFP + VSY);
            e_rgb = '0;
`ifdef VGA_UNDERFLOW_RESYNC_EN
            if (uf && h == HT - 1 && v == VT - 1) fl = 1'b1;
`endif
            if (act) begin
                if (q.size() > 0) e_rgb = q.pop_front();
                else uf = 1'b1;
            end
            t++;
            if (fl) begin
                run = 1'b0;
                t = 0;
            end
        end
        if (fl) q.delete();
        else if (push) q.push_back(pixel_data);
        if (push) begin
            src_idx++;
            cur_data = gen_pixel(src_idx);
        end
    endtask

    task automatic monitor();
        cyc++;
        if (!mon_en) begin
            de_rise = 0; frame_de = 0; hs_fall = 0; vs_fall = 0;
        end else begin
            if (vga_de && !p_de) begin
                if (de_rise == 0 || cyc - de_rise != HT) frame_de = cyc;
                de_rise = cyc;
            end
            if (!vga_de && p_de && de_rise != 0) check("de_width", cyc - de_rise, HA);
            if (!vga_hs && p_hs) begin
                if (hs_fall != 0) check("hs_period", cyc - hs_fall, HT);
                if (de_rise != 0 && cyc - de_rise < HT) check("hs_offset", cyc - de_rise, HA + HFP);
                hs_fall = cyc;
            end
            if (vga_hs && !p_hs && hs_fall != 0) check("hs_width", cyc - hs_fall, HSY);
            if (!vga_vs && p_vs) begin
                if (vs_fall != 0) check("frame_period", cyc - vs_fall, HT * VT);
                if (frame_de != 0) check("vs_offset", cyc - frame_de, (VA + VFP) * HT);
                vs_fall = cyc;
            end
            if (vga_vs && !p_vs && vs_fall != 0) check("vs_width", cyc - vs_fall, VSY * HT);
        end
        p_de = vga_de; p_hs = vga_hs; p_vs = vga_vs;
    endtask

    task automatic step(input string tag);
        pixel_valid = src_on && (src_limit == 0 || src_idx < src_limit)
                      && ($urandom_range(99, 0) < src_prob);
        pixel_data  = cur_data;
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check(tag, obs_vec(), exp_vec());
        monitor();
    endtask

    // Entered and left on a falling clock edge.
    task automatic apply_reset(input string tag);
        reset = 1'b1;
        pixel_valid = 1'b0;
        #1;
        check({tag, "_reset"}, {4'b0, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_de, underflow},
              {4'b0, 24'h0, 1'b1, 1'b1, 1'b0, 1'b0});
        model_clear();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          seen;
        bit          reached;
        int unsigned cnt;
        src_on = 1'b0; src_prob = 100; src_limit = 0;
        mon_en = 1'b0; cyc = 0; p_de = 1'b0; p_hs = 1'b1; p_vs = 1'b1;
        de_rise = 0; frame_de = 0; hs_fall = 0; vs_fall = 0;
        model_clear();
        @(negedge clk);
        apply_reset("por");

        for (int unsigned i = 0; i < 200; i++) step("idle");

        src_on = 1'b1;
        mon_en = 1'b1;
        seen = 1'b0;
        for (int unsigned i = 0; i < 2 * HT * VT + 100; i++) begin
            step("stream");
            if (vga_de && !seen) begin
                seen = 1'b1;
                check("first_pixel", {vga_r, vga_g, vga_b}, 24'h0000FF);
            end
        end
        check("stream_first_seen", seen, 1);
        check("stream_no_underflow", underflow, 0);
        mon_en = 1'b0;

        apply_reset("starve");
        src_limit = 100;
        cnt = 0;
        for (int unsigned i = 0; i < 2 * HT * VT + 50; i++) begin
            step("starve");
            if (vga_de && {vga_r, vga_g, vga_b} != 24'h0) cnt++;
        end
        check("starve_pixels", cnt, 100);
        check("underflow_sticky", underflow, 1);

        src_limit = 0;
        src_prob = 85;
        for (int unsigned i = 0; i < 1500; i++) step("random");

        apply_reset("mid_pre");
        src_prob = 100;
        reached = 1'b0;
        for (int unsigned i = 0; i < 2000 && !reached; i++) begin
            step("mid");
            if (run && t == 5 * HT + 10) reached = 1'b1;
        end
        check("mid_reached", reached, 1);
        apply_reset("mid");
        src_on = 1'b0;
        for (int unsigned i = 0; i < 20; i++) step("post_reset_idle");
        src_on = 1'b1;
        seen = 1'b0;
        for (int unsigned i = 0; i < HT * VT + 100; i++) begin
            step("restart");
            if (vga_de && !seen) begin
                seen = 1'b1;
                check("restart_first_pixel", {vga_r, vga_g, vga_b}, 24'h0000FF);
            end
        end
        check("restart_seen", seen, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_stream_out.md
Name: vga_stream_out

Overview:
Downstream consumer of the pixel stream from the test pattern generator and other pixel sources. Buffers incoming 24-bit pixels in a small FIFO. Generates 640x480@60 VGA timing and drives RGB, sync and data-enable outputs. Sits at the end of the VGA driver chain, directly before the DAC/pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width
V_BP, 33, vertical back porch
FIFO_DEPTH, 16, pixel FIFO entries (power of 2, >=4)

Ports:
clk  in  1  pixel clock
reset  in  1  asynchronous, active-high reset
pixel_valid  in  1  upstream has a pixel on pixel_data
pixel_ready  out  1  FIFO can accept; transfer when pixel_valid && pixel_ready
pixel_data  in  24  {R[23:16],G[15:8],B[7:0]}
vga_r  out  8  red
vga_g  out  8  green
vga_b  out  8  blue
vga_hs  out  1  hsync, active-low
vga_vs  out  1  vsync, active-low
vga_de  out  1  high during active video
underflow  out  1  sticky: FIFO empty during an active pixel

Behaviour:
- Reset values, applied asynchronously while reset is high:
  - vga_r/g/b = 0; vga_hs = 1; vga_vs = 1; vga_de = 0; underflow = 0.
  - FIFO empty; h_cnt = v_cnt = 0; state IDLE.
- pixel_ready = !fifo_full. Asserted from the first clock after reset deasserts.
- A write occurs on each clock where pixel_valid && pixel_ready. Upstream may hold valid high continuously.
- Simultaneous write and read on a full FIFO is not possible, because ready is low when full.
- Simultaneous write and read on an empty FIFO: the read sees empty (underflow rule). The write is stored.
- FSM states:
  - IDLE: counters held at 0, outputs blanked (sync high, de 0, RGB 0). Go to RUN when FIFO level >= FIFO_DEPTH/2.
  - RUN: free-running counters.
    - h_cnt counts 0..H_TOTAL-1 and wraps.
    - v_cnt increments on h_cnt wrap and counts 0..V_TOTAL-1 (H_TOTAL = 800, V_TOTAL = 525 at defaults).
- Region decode, with active first:
  - active = h_cnt < H_ACTIVE && v_cnt < V_ACTIVE
  - hs_n low when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC
  - vs_n low for V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (whole lines)
- FIFO read strobe = RUN && active. The FIFO is first-word-fall-through; head data is valid combinationally.
- All VGA outputs are registered: outputs at cycle n+1 reflect the counters at cycle n (1-cycle latency). Sync and de share the same pipeline stage as RGB.
- Active pixel with FIFO empty: RGB = 0, no pop, underflow set (sticky until reset). Timing continues.
- Counters are 10 bits wide. Comparisons are unsigned. Wrap is exact, with no extra cycle.
- Reset mid-frame returns to IDLE and discards the FIFO contents.
- Frame alignment: the first pixel popped after IDLE->RUN appears at h_cnt = 0, v_cnt = 0.

Optional Feature:
- Macro: VGA_UNDERFLOW_RESYNC_EN.
- Defined:
  - After an underflow, on the cycle where h_cnt = H_TOTAL-1 and v_cnt = V_TOTAL-1 (end of frame), flush the FIFO and return to IDLE.
  - The sticky underflow flag stays set.
  - Restart realigns the frame with the pixel source.
- Undefined: no resync. The stream simply continues after the gap, and may be pixel-shifted.

Decomposition:
- Package vga_pkg holds:
  - timing defaults and derived H_TOTAL/V_TOTAL, HS_START/HS_END, VS_START/VS_END
  - state encoding IDLE = 1'b0, RUN = 1'b1
  - RGB888 field positions
- One sub-module, vga_pixel_fifo (parameterised depth, FWFT, full/empty/level, synchronous flush).
- Timing counters and FSM live in vga_stream_out.

Test Plan:
- Reset then hold pixel_valid = 0 -> pixel_ready = 1, vga_hs = vga_vs = 1, vga_de = 0, state stays IDLE indefinitely.
- Continuous valid data with 0x0000FF as pixel 0 of each line -> RUN after 8 writes; vga_de first high one cycle after h_cnt = 0, v_cnt = 0 with RGB = 0x0000FF; de stays high for exactly 640 clocks per line.
- Timing check over 2 frames:
  - vga_hs low for 96 clocks, starting 656 clocks after the de rising edge; line period 800.
  - vga_vs low for 2 lines starting at line 490; frame period 420000 clocks.
- Backpressure: feed exactly one pixel per clock and verify pixel_ready deasserts at FIFO level 16 -> no pixel dropped or duplicated (scoreboard over 1 frame).
- Starve input after 100 active pixels -> RGB = 0 for the remaining active pixels, underflow = 1 and stays set; with VGA_UNDERFLOW_RESYNC_EN, FSM returns to IDLE at end of frame.
- Assert reset at h_cnt = 300, v_cnt = 200 -> all outputs at reset values immediately, FIFO empty, clean restart from 0,0.
